// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a single-port-style word memory.
// Independent write and read engines, one burst in flight per direction.
//
//   state  | meaning
//   W_IDLE | waiting for a write address, awready high
//   W_DATA | accepting write beats, wready high
//   W_RESP | presenting bresp until bready
//   R_IDLE | waiting for a read address, arready high
//   R_DATA | presenting a read beat, rvalid high
module axi4_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic                  w_err, w_wlast_err;

  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_nxt;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic                  r_err, ar_err;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, ar_hs, r_hs;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> OFF);
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size != 3'(OFF)) || (burst == 2'b11) || bad_wrap;
  endfunction

  // Wrap window is (len+1) beats wide; only the in-window bits advance.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] inc, mask;
    inc  = a + ADDR_WIDTH'(BYTES);
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << OFF) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign ar_err = burst_err(arsize, arburst, arlen);
  assign r_nxt  = next_addr(r_addr, r_len, r_burst);

  assign bresp = bvalid ? {w_err | w_wlast_err, 1'b0} : 2'b00;
  assign rresp = rvalid ? {r_err, 1'b0} : 2'b00;
  assign rlast = rvalid && (r_cnt == r_len);
  assign rdata = rst ? '0 : rdata_q;

  // Write state register.
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write next-state and handshake outputs; everything is held low during reset.
  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    if (!rst) begin
      unique case (w_state)
        W_IDLE: begin
          awready = 1'b1;
          if (awvalid) w_next = W_DATA;
        end
        W_DATA: begin
          wready = 1'b1;
          if (wvalid && (w_cnt == w_len)) w_next = W_RESP;
        end
        W_RESP: begin
          bvalid = 1'b1;
          if (bready) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  // Write burst bookkeeping: address walk, beat count and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr      <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_burst     <= '0;
      w_err       <= 1'b0;
      w_wlast_err <= 1'b0;
    end else if (aw_hs) begin
      w_addr      <= awaddr;
      w_len       <= awlen;
      w_burst     <= awburst;
      w_cnt       <= '0;
      w_err       <= burst_err(awsize, awburst, awlen);
      w_wlast_err <= 1'b0;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_len, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      if (wlast != (w_cnt == w_len)) w_wlast_err <= 1'b1;
    end
  end

  // Memory commit; a bad-config burst never touches storage. Not reset.
  always_ff @(posedge clk) begin
    if (w_hs && !w_err) mem[word_idx(w_addr)] <= wdata;
  end

  // Read state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Read next-state and handshake outputs.
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        R_IDLE: begin
          arready = 1'b1;
          if (arvalid) r_next = R_DATA;
        end
        R_DATA: begin
          rvalid = 1'b1;
          if (rready && (r_cnt == r_len)) r_next = R_IDLE;
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  // Read data prefetch: the next beat is loaded on the same edge as the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      rdata_q <= '0;
    end else if (ar_hs) begin
      r_addr  <= araddr;
      r_len   <= arlen;
      r_burst <= arburst;
      r_cnt   <= '0;
      r_err   <= ar_err;
      rdata_q <= ar_err ? '0 : mem[word_idx(araddr)];
    end else if (r_hs && (r_cnt != r_len)) begin
      r_addr  <= r_nxt;
      r_cnt   <= r_cnt + 8'd1;
      rdata_q <= r_err ? '0 : mem[word_idx(r_nxt)];
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: drivers push expected responses,
// a negedge monitor pops and compares whenever a B or R handshake occurs.
module tb_axi4_slave_mem;
  localparam int AW = 32, DW = 128, DEPTH = 256, BYTES = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata;
  logic          arvalid, arready, rvalid, rready, rlast;

  always #5 clk = ~clk;

  axi4_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } rbeat_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  rbeat_t        exp_r [$];
  logic [1:0]    exp_b [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout waiting for %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference address of beat i, computed from the burst window directly.
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] start, input int len,
                                               input logic [1:0] burst, input int i);
    longint unsigned b, lower, s;
    s = longint'(start);
    case (burst)
      2'b00: return start;
      2'b10: begin
        b     = longint'((len + 1) * BYTES);
        lower = (s / b) * b;
        return AW'(lower + ((s - lower) + longint'(i * BYTES)) % b);
      end
      default: return start + AW'(i * BYTES);
    endcase
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a / BYTES) % DEPTH);
  endfunction

  function automatic bit cfg_err(input logic [2:0] size, input logic [1:0] burst, input int len);
    return (size != 3'd4) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int bad_last, input int abort_at);
    bit err, lerr;
    int t;
    err  = cfg_err(size, burst, len);
    lerr = 0;
    awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 100);
    if (!awready) begin timeout("awready"); awvalid = 1'b0; return; end
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("awready_after_abort", awready, 1'b1);
        tick();
        return;
      end
      repeat ($urandom_range(0, 1)) tick();
      wdata  = rand_data();
      wlast  = (i == len) ^ (i == bad_last);
      wvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!wready && t < 100);
      if (!wready) begin timeout("wready"); wvalid = 1'b0; return; end
      if (wlast != (i == len)) lerr = 1;
      if (!err) ref_mem[widx(beat_addr(addr, len, burst, i))] = wdata;
      tick();
      wvalid = 1'b0;
    end
    wlast = 1'b0;
    exp_b.push_back((err || lerr) ? 2'b10 : 2'b00);
    repeat ($urandom_range(0, 2)) tick();
    bready = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bvalid && t < 100);
    if (!bvalid) timeout("bvalid");
    tick();
    bready = 1'b0;
  endtask

  // mode 0: rready always high, 1: random, 2: repeating 1,0,0,1.
  task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input int mode, input int abort_at);
    bit     err;
    bit     pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int     t, got, k;
    rbeat_t e;
    err = cfg_err(size, burst, len);
    for (int i = 0; i <= len; i++) begin
      e.data = err ? '0 : ref_mem[widx(beat_addr(addr, len, burst, i))];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == len);
      exp_r.push_back(e);
    end
    araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 100);
    if (!arready) begin timeout("arready"); arvalid = 1'b0; return; end
    tick();
    arvalid = 1'b0;
    got = 0; k = 0; t = 0;
    while (got <= len && t < 4000) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : pat[k % 4];
      k++;
      @(negedge clk);
      t++;
      if (rvalid && rready) got++;
      tick();
      if (abort_at >= 0 && got == abort_at) return;
    end
    rready = 1'b0;
    if (got <= len) timeout("read beats");
  endtask

  // Monitor: compares every B/R handshake against the scoreboard and checks
  // that a stalled read beat does not change.
  initial begin
    bit            stalled;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    rbeat_t        e;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 0;
      end else begin
        if (stalled && rvalid) begin
          check("rdata_stable", rdata, hold_data);
          check("rlast_stable", rlast, hold_last);
        end
        stalled   = rvalid && !rready;
        hold_data = rdata;
        hold_last = rlast;
        if (rvalid && rready) begin
          if (exp_r.size() == 0) timeout("unexpected_r_beat_expected_none");
          else begin
            e = exp_r.pop_front();
            check("rdata", rdata, e.data);
            check("rresp", rresp, e.resp);
            check("rlast", rlast, e.last);
          end
        end
        if (bvalid && bready) begin
          if (exp_b.size() == 0) timeout("unexpected_b_expected_none");
          else check("bresp", bresp, exp_b.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bu;
    int         ln, md;
    logic [2:0] sz;
    logic [AW-1:0] ad;

    rst = 1'b1;
    awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready",  wready,  1'b0);
    check("rst_bvalid",  bvalid,  1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_rvalid",  rvalid,  1'b0);
    check("rst_rlast",   rlast,   1'b0);
    check("rst_bresp",   bresp,   2'b00);
    check("rst_rresp",   rresp,   2'b00);
    check("rst_rdata",   rdata,   '0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", awready, 1'b1);
    check("post_rst_arready", arready, 1'b1);
    tick();

    // Fill the whole memory with one maximum-length burst.
    do_write(32'h0, 255, 3'd4, 2'b01, -1, -1);

    do_write(32'h100, 3, 3'd4, 2'b01, -1, -1);
    do_read (32'h100, 3, 3'd4, 2'b01, 0, -1);
    do_read (32'h130, 3, 3'd4, 2'b10, 0, -1);
    do_read (32'h140, 3, 3'd4, 2'b01, 2, -1);

    do_write(32'h200, 3, 3'd2, 2'b01, -1, -1);
    do_read (32'h200, 3, 3'd4, 2'b01, 0, -1);
    do_write(32'h200, 3, 3'd4, 2'b11, -1, -1);
    do_read (32'h200, 3, 3'd4, 2'b01, 1, -1);
    do_read (32'h200, 3, 3'd4, 2'b11, 0, -1);

    do_write(32'h300, 3, 3'd4, 2'b01, 1, -1);
    do_read (32'h300, 3, 3'd4, 2'b01, 0, -1);

    do_write(32'h500, 3, 3'd4, 2'b00, -1, -1);
    do_read (32'h500, 3, 3'd4, 2'b00, 0, -1);
    do_write(32'h1FF0, 1, 3'd4, 2'b01, -1, -1);
    do_read (32'h0FF0, 1, 3'd4, 2'b01, 0, -1);

    // Write aborted by reset after two beats.
    do_write(32'h400, 3, 3'd4, 2'b01, -1, 2);
    do_read (32'h400, 3, 3'd4, 2'b01, 0, -1);

    // Read aborted by reset while beat 2 is presented.
    do_read(32'h600, 7, 3'd4, 2'b01, 0, 2);
    rst = 1'b1;
    exp_r.delete();
    @(negedge clk);
    check("abort_rvalid", rvalid, 1'b0);
    tick();
    rst = 1'b0;
    rready = 1'b0;
    @(negedge clk);
    check("abort_arready", arready, 1'b1);
    check("abort_rvalid_after", rvalid, 1'b0);
    tick();

    for (int n = 0; n < 40; n++) begin
      bu = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (bu == 2'b10) begin
        md = $urandom_range(0, 4);
        ln = (md == 4) ? 2 : (1 << (md + 1)) - 1;
      end else begin
        ln = $urandom_range(0, 15);
      end
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      ad = AW'($urandom_range(0, 32'h1FFF));
      if ($urandom_range(0, 3) != 0) ad = ad & ~AW'(15);
      if ($urandom_range(0, 1) == 0)
        do_write(ad, ln, sz, bu, ($urandom_range(0, 5) == 0) ? $urandom_range(0, ln) : -1, -1);
      else
        do_read(ad, ln, sz, bu, 1, -1);
    end

    repeat (5) tick();
    check("r_scoreboard_empty", 32'(exp_r.size()), 32'd0);
    check("b_scoreboard_empty", 32'(exp_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem.md
AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 128: data bus width in bits; BYTES = DATA_WIDTH/8.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: number of DATA_WIDTH-bit memory words (power of two).
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have ports awvalid in 1, awready out 1, awaddr in ADDR_WIDTH, awlen in 8, awsize in 3, awburst in 2: write address channel.
REQ-007 SHALL have ports wvalid in 1, wready out 1, wdata in DATA_WIDTH, wlast in 1: write data channel.
REQ-008 SHALL have ports bvalid out 1, bready in 1, bresp out 2: write response channel.
REQ-009 SHALL have ports arvalid in 1, arready out 1, araddr in ADDR_WIDTH, arlen in 8, arsize in 3, arburst in 2: read address channel.
REQ-010 SHALL have ports rvalid out 1, rready in 1, rdata out DATA_WIDTH, rresp out 2, rlast out 1: read data channel.

Function
REQ-011 SHALL run independent write FSM (W_IDLE, W_DATA, W_RESP) and read FSM (R_IDLE, R_DATA); one burst per channel in flight.
REQ-012 Write FSM SHALL assert awready only in W_IDLE; on awvalid&&awready, latch addr/len/size/burst, clear beat counter, go to W_DATA next cycle.
REQ-013 W_DATA SHALL assert wready=1; each wvalid&&wready beat writes wdata to mem[word index] at that clock edge and advances address.
REQ-014 W_DATA SHALL move to W_RESP on the beat where beat counter == latched len, regardless of wlast.
REQ-015 W_RESP SHALL hold bvalid=1 and stable bresp until bready; on bvalid&&bready go to W_IDLE (awready=1 the following cycle).
REQ-016 Read FSM SHALL assert arready only in R_IDLE; on arvalid&&arready, latch burst fields, load rdata from mem[first word], enter R_DATA with rvalid=1 next cycle (1-cycle latency).
REQ-017 R_DATA SHALL hold rvalid, rdata, rresp, rlast stable while rready=0; on rvalid&&rready load the next beat's rdata the same edge, zero bubbles.
REQ-018 rlast SHALL be 1 exactly when beat counter == latched len; final handshake returns read FSM to R_IDLE.
REQ-019 Word index SHALL be (address >> log2(BYTES)) modulo MEM_DEPTH; out-of-range addresses alias, no error.
REQ-020 Next address: FIXED (2'b00) unchanged; INCR (2'b01) addr+BYTES, ADDR_WIDTH wrap-around; WRAP (2'b10) (addr & ~(B-1)) | ((addr+BYTES) & (B-1)), B=(len+1)*BYTES.
REQ-021 Response SHALL be SLVERR (2'b10) if awsize/arsize != log2(BYTES), burst == 2'b11, or WRAP with len not in {1,3,7,15}; else OKAY (2'b00).
REQ-022 On error bursts, SHALL still complete full handshake for len+1 beats, suppress all memory writes, return rdata=0.
REQ-023 Write SHALL also return SLVERR if wlast mismatches (wlast=1 before final beat or 0 on final beat); memory writes of that burst still occur.
REQ-024 Same-edge read load and write commit to same word: read SHALL return pre-write data.
REQ-025 Beat counter SHALL be 8 bits; max burst 256 beats.

Reset
REQ-026 While rst=1: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, rdata = 0; both FSMs to idle; counters cleared.
REQ-027 First cycle after rst deasserts: awready=1, arready=1.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 rst asserted mid-burst SHALL abort both bursts with no further writes and no bvalid/rvalid for the aborted bursts.

Verification
REQ-030 INCR write awaddr=0x100, awlen=3, awsize=4, then read same -> bresp=OKAY; 4 rdata beats match written, rlast on 4th, rresp=OKAY.
REQ-031 WRAP read araddr=0x130, arlen=3, size=4 -> beat addresses 0x130,0x100,0x110,0x120.
REQ-032 Read with rready toggling 1,0,0,1 each beat -> rdata/rlast stable while stalled, no beat lost/duplicated.
REQ-033 Write awsize=2 or awburst=2'b11 -> 4 beats accepted, bresp=2'b10, memory unchanged on read-back.
REQ-034 Write awlen=3 with wlast=1 on beat 2 -> 4 beats accepted, bresp=2'b10.
REQ-035 rst pulse during beat 2 of 8-beat read -> rvalid=0 next cycle, arready=1 cycle after rst drops.
